// File: rtl/pwm_bank_pkg.sv
// rtl/pwm_bank_pkg.sv - register map and CTRL bit positions for pwm_bank
package pwm_bank_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_CH_EN  = 1;
  localparam int CH_BASE    = 4;
  localparam int CH_STRIDE  = 4;

  localparam int OFS_PER_L  = 0;
  localparam int OFS_PER_H  = 1;
  localparam int OFS_DUTY_L = 2;
  localparam int OFS_DUTY_H = 3;

  localparam int CTRL_EN     = 7;
  localparam int CTRL_CENTER = 1;
  localparam int CTRL_HOLD   = 0;

  function automatic int ch_addr(input int c, input int ofs);
    return CH_BASE + CH_STRIDE * c + ofs;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: counter, active period/duty, compare, period_end
// PWM_CENTER_ALIGNED_EN adds the up/down counting mode.
module pwm_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
  input  logic             hold,
`ifdef PWM_CENTER_ALIGNED_EN
  input  logic             center,
`endif
  input  logic [CNT_W-1:0] stg_per,
  input  logic [CNT_W-1:0] stg_duty,
  output logic             pwm_out,
  output logic             period_end
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_per;
  logic [CNT_W-1:0] act_duty;
  logic             at_top;
  logic             wrap;

  assign at_top = (cnt == act_per - CNT_W'(1));

`ifdef PWM_CENTER_ALIGNED_EN
  logic act_center;
  logic down;
  // Center mode ends its period on the way back down at zero.
  assign wrap = act_center ? (down && (cnt == '0)) : at_top;
`else
  assign wrap = at_top;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      act_per    <= '0;
      act_duty   <= '0;
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      act_center <= 1'b0;
      down       <= 1'b0;
`endif
    end else begin
      period_end <= 1'b0;
      if (!run) begin
        cnt     <= '0;
        pwm_out <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        down    <= 1'b0;
`endif
        if (!hold) begin
          act_per  <= stg_per;
          act_duty <= stg_duty;
`ifdef PWM_CENTER_ALIGNED_EN
          act_center <= center;
`endif
        end
      end else if (tick) begin
        pwm_out <= (act_per != '0) && (cnt < act_duty);
        if (act_per == '0 || wrap) begin
          // Zero period reloads on every tick so a new setting can start it.
          cnt        <= '0;
          period_end <= (act_per != '0);
`ifdef PWM_CENTER_ALIGNED_EN
          down       <= 1'b0;
`endif
          if (!hold) begin
            act_per  <= stg_per;
            act_duty <= stg_duty;
`ifdef PWM_CENTER_ALIGNED_EN
            act_center <= center;
`endif
          end
`ifdef PWM_CENTER_ALIGNED_EN
        end else if (act_center && !down && at_top) begin
          down <= 1'b1;
        end else if (act_center && down) begin
          cnt <= cnt - CNT_W'(1);
`endif
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - N-channel double-buffered PWM bank with byte register interface
// PWM_CENTER_ALIGNED_EN enables CTRL b1 center-aligned mode.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] period_end
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic              ctrl_en;
  logic              ctrl_hold;
  logic              ctrl_center;
  logic [NUM_CH-1:0] ch_en;
  logic [7:0]        per_l  [NUM_CH];
  logic [7:0]        per_h  [NUM_CH];
  logic [7:0]        duty_l [NUM_CH];
  logic [7:0]        duty_h [NUM_CH];
  logic [7:0]        rd_next;
  logic [PW-1:0]     presc;
  logic              tick;

  assign tick = (presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) presc <= '0;
    else               presc <= presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en     <= 1'b0;
      ctrl_hold   <= 1'b0;
      ctrl_center <= 1'b0;
      ch_en       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        per_l[c]  <= '0;
        per_h[c]  <= '0;
        duty_l[c] <= '0;
        duty_h[c] <= '0;
      end
    end else if (wr_en) begin
      if (wr_addr == ADDR_W'(REG_CTRL)) begin
        ctrl_en   <= wr_data[CTRL_EN];
        ctrl_hold <= wr_data[CTRL_HOLD];
`ifdef PWM_CENTER_ALIGNED_EN
        ctrl_center <= wr_data[CTRL_CENTER];
`endif
      end
      if (wr_addr == ADDR_W'(REG_CH_EN)) ch_en <= wr_data[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_addr == ADDR_W'(ch_addr(c, OFS_PER_L)))  per_l[c]  <= wr_data;
        if (wr_addr == ADDR_W'(ch_addr(c, OFS_PER_H)))  per_h[c]  <= wr_data;
        if (wr_addr == ADDR_W'(ch_addr(c, OFS_DUTY_L))) duty_l[c] <= wr_data;
        if (wr_addr == ADDR_W'(ch_addr(c, OFS_DUTY_H))) duty_h[c] <= wr_data;
      end
    end
  end

  // Readback shows staged values, not what the channels are currently running.
  always_comb begin
    rd_next = 8'h00;
    if (rd_addr == ADDR_W'(REG_CTRL)) begin
      rd_next[CTRL_EN]     = ctrl_en;
      rd_next[CTRL_CENTER] = ctrl_center;
      rd_next[CTRL_HOLD]   = ctrl_hold;
    end
    if (rd_addr == ADDR_W'(REG_CH_EN)) rd_next = 8'(ch_en);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_addr == ADDR_W'(ch_addr(c, OFS_PER_L)))  rd_next = per_l[c];
      if (rd_addr == ADDR_W'(ch_addr(c, OFS_PER_H)))  rd_next = per_h[c];
      if (rd_addr == ADDR_W'(ch_addr(c, OFS_DUTY_L))) rd_next = duty_l[c];
      if (rd_addr == ADDR_W'(ch_addr(c, OFS_DUTY_H))) rd_next = duty_h[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= 8'h00;
    else       rd_data <= rd_next;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [15:0] per_full;
    logic [15:0] duty_full;
    assign per_full  = {per_h[c], per_l[c]};
    assign duty_full = {duty_h[c], duty_l[c]};

    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .run        (ctrl_en & ch_en[c]),
      .hold       (ctrl_hold),
`ifdef PWM_CENTER_ALIGNED_EN
      .center     (ctrl_center),
`endif
      .stg_per    (per_full[CNT_W-1:0]),
      .stg_duty   (duty_full[CNT_W-1:0]),
      .pwm_out    (pwm_out[c]),
      .period_end (period_end[c])
    );
  end

endmodule
